// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the datapath and the multi-cycle data memory.
interface data_mem_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  busy, done, fault, rdata
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output busy, done, fault, rdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle byte/half/word data memory with a req/busy/done handshake,
// load extension and range/alignment fault detection.
module data_mem_ctrl #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_ctrl_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        we_q, sext_q, fault_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  logic [31:0] mem [DEPTH] = '{default: '0};

  logic [AW-1:0] idx;
  logic          bad, access;
  logic [3:0]    be;
  logic [31:0]   mask, wlanes, word, wmerged, ldval;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  always_comb begin
    idx    = addr_q[AW+1:2];
    word   = mem[idx];
    access = (state_q == WAIT) && (cnt_q == '0);
    bad    = (size_q == 2'b11)
           | ((size_q == 2'b01) & addr_q[0])
           | ((size_q == 2'b10) & (|addr_q[1:0]))
           | (|addr_q[31:AW+2]);

    be     = '0;
    wlanes = wdata_q;
    case (size_q)
      2'b00: begin
        be     = 4'b0001 << addr_q[1:0];
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = '0;
    endcase
    mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wmerged = (wlanes & mask) | (word & ~mask);

    byte_v = word[{addr_q[1:0], 3'b000} +: 8];
    half_v = addr_q[1] ? word[31:16] : word[15:0];
    case (size_q)
      2'b00:   ldval = {{24{sext_q & byte_v[7]}}, byte_v};
      2'b01:   ldval = {{16{sext_q & half_v[15]}}, half_v};
      default: ldval = word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM has no reset; an async reset forces IDLE so a pending store can never commit.
  always_ff @(posedge clk) begin
    if (access && we_q && !bad) mem[idx] <= wmerged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.req) begin
          cnt_q   <= 4'(LATENCY - 1);
          we_q    <= bus.we;
          sext_q  <= bus.sign_ext;
          size_q  <= bus.size;
          addr_q  <= bus.addr;
          wdata_q <= bus.wdata;
        end
        WAIT: if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          fault_q <= bad;
          if (bad)        rdata_q <= '0;
          else if (!we_q) rdata_q <= ldval;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy  = (state_q != IDLE);
    bus.done  = (state_q == RESP);
    bus.fault = (state_q == RESP) && fault_q;
    bus.rdata = rdata_q;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: three instances (LATENCY 2, 1, 15) share one stimulus bus,
// a byte-array reference model predicts each response.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  int          sel = 0;

  data_mem_ctrl_if ifa ();
  data_mem_ctrl_if ifb ();
  data_mem_ctrl_if ifc ();

  assign ifa.req = req && (sel == 0);
  assign ifb.req = req && (sel == 1);
  assign ifc.req = req && (sel == 2);
  assign ifa.we = we;   assign ifb.we = we;   assign ifc.we = we;
  assign ifa.size = size; assign ifb.size = size; assign ifc.size = size;
  assign ifa.sign_ext = sign_ext; assign ifb.sign_ext = sign_ext; assign ifc.sign_ext = sign_ext;
  assign ifa.addr = addr; assign ifb.addr = addr; assign ifc.addr = addr;
  assign ifa.wdata = wdata; assign ifb.wdata = wdata; assign ifc.wdata = wdata;

  data_mem_ctrl #(.DEPTH(256), .LATENCY(2))  dut_a (.clk(clk), .reset(reset), .bus(ifa));
  data_mem_ctrl #(.DEPTH(256), .LATENCY(1))  dut_b (.clk(clk), .reset(reset), .bus(ifb));
  data_mem_ctrl #(.DEPTH(256), .LATENCY(15)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  logic [2:0]  dn, bs, ft;
  logic [31:0] rd [3];
  assign dn = {ifc.done, ifb.done, ifa.done};
  assign bs = {ifc.busy, ifb.busy, ifa.busy};
  assign ft = {ifc.fault, ifb.fault, ifa.fault};
  assign rd[0] = ifa.rdata;
  assign rd[1] = ifb.rdata;
  assign rd[2] = ifc.rdata;

  int lat_of [3] = '{2, 1, 15};

  typedef struct {
    int          id;
    logic        fault;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t        sb [$];
  logic [7:0]  mm [3][1024];
  logic [31:0] last [3];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, 1 KiB per instance.
  function automatic void issue_model(int s, logic w, logic [1:0] sz, logic se,
                                      logic [31:0] a, logic [31:0] d, string nm);
    exp_t        e;
    int          nb;
    logic [31:0] v;
    logic        f;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    f  = (sz == 2'd3) || ((a % nb) != 0) || (a >= 32'd1024);
    if (f) begin
      last[s] = '0;
    end else if (w) begin
      for (int i = 0; i < nb; i++) mm[s][a + i] = d[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (32'(mm[s][a + i]) << (8 * i));
      if (se && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      last[s] = v;
    end
    e.id = s; e.fault = f; e.rdata = last[s]; e.name = nm;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (dn != 3'b000) begin
      exp_t e;
      int   id;
      id = dn[0] ? 0 : (dn[1] ? 1 : 2);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done on dut %0d expected none", id);
      end else begin
        e = sb.pop_front();
        if (id != e.id || ft[id] !== e.fault || rd[id] !== e.rdata) begin
          errors++;
          $display("FAIL %s: got dut %0d fault %b rdata %h expected dut %0d fault %b rdata %h",
                   e.name, id, ft[id], rd[id], e.id, e.fault, e.rdata);
        end
      end
    end
  end

  task automatic wait_idle(int s);
    int n;
    n = 0;
    @(negedge clk);
    while (bs[s] && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("idle_timeout", 32'(n), 32'(0));
  endtask

  task automatic access(int s, logic w, logic [1:0] sz, logic se,
                        logic [31:0] a, logic [31:0] d, string nm);
    int n;
    wait_idle(s);
    sel = s; we = w; size = sz; sign_ext = se; addr = a; wdata = d; req = 1'b1;
    issue_model(s, w, sz, se, a, d, nm);
    @(posedge clk); #1;
    req = 1'b0;
    chk({nm, "_busy"}, 32'(bs[s]), 32'(1));
    n = 0;
    while (!dn[s] && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, 32'(n), 32'(lat_of[s]));
  endtask

  task automatic first_scenario(int s);
    access(s, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, "st_w10");
    access(s, 1'b0, 2'd2, 1'b0, 32'h10, '0, "ld_w10");
    access(s, 1'b0, 2'd0, 1'b0, 32'h10, '0, "ld_b10");
    access(s, 1'b0, 2'd0, 1'b0, 32'h13, '0, "ld_b13");
    access(s, 1'b0, 2'd1, 1'b0, 32'h12, '0, "ld_h12");
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      last[k] = '0;
      for (int j = 0; j < 1024; j++) mm[k][j] = '0;
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset_state", {bs[k], dn[k], ft[k], rd[k][28:0]}, 32'(0) | {3'b000, 29'(rd[k] & 32'h0)});
    for (int k = 0; k < 3; k++) chk("reset_rdata", rd[k], 32'h0);
    reset = 1'b1;

    // Directed data, lanes, extension and faults on the LATENCY=2 instance.
    first_scenario(0);
    access(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB, "st_b11");
    access(0, 1'b0, 2'd2, 1'b0, 32'h10, '0, "ld_w10_merged");
    access(0, 1'b1, 2'd0, 1'b0, 32'h20, 32'h0000_0080, "st_b20");
    access(0, 1'b0, 2'd0, 1'b1, 32'h20, '0, "ld_b20_sext");
    access(0, 1'b0, 2'd0, 1'b0, 32'h20, '0, "ld_b20_zext");
    access(0, 1'b0, 2'd1, 1'b0, 32'h11, '0, "flt_h11");
    access(0, 1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFF_FFFF, "flt_st_w22");
    access(0, 1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFF_FFFF, "flt_size3");
    access(0, 1'b0, 2'd2, 1'b0, 32'h400, '0, "flt_range");
    access(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hFFFF_FFFF, "flt_st_range");
    access(0, 1'b0, 2'd2, 1'b0, 32'h20, '0, "ld_w20_unchanged");

    // Held request: only requests presented while idle are executed.
    wait_idle(0);
    sel = 0; we = 1'b0; size = 2'd2; sign_ext = 1'b0; req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      addr = {22'd0, 8'($urandom_range(0, 7)), 2'b00};
      if (!bs[0]) issue_model(0, 1'b0, 2'd2, 1'b0, addr, '0, "held_req");
      if (i == 1 || i == 2) chk("held_busy", 32'(bs[0]), 32'(1));
      @(negedge clk);
    end
    req = 1'b0;

    // Reset during WAIT of a store aborts it.
    wait_idle(0);
    sel = 0; we = 1'b1; size = 2'd2; addr = 32'h30; wdata = 32'hDEAD_BEEF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    chk("abort_busy_before", 32'(bs[0]), 32'(1));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(bs[0]), 32'(0));
    chk("abort_done", 32'(dn[0]), 32'(0));
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(dn), 32'(0));
    reset = 1'b1;
    for (int k = 0; k < 3; k++) last[k] = '0;
    access(0, 1'b0, 2'd2, 1'b0, 32'h30, '0, "ld_w30_after_abort");

    // Same first scenario at the latency extremes.
    first_scenario(1);
    first_scenario(2);

    // Random traffic across all instances.
    for (int i = 0; i < 50; i++) begin
      int          s;
      logic [1:0]  sz;
      logic [31:0] a;
      s  = $urandom_range(0, 2);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 32'h41F));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      access(s, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "random");
    end

    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
      chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
